// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU arbiter: opcode encodings, canned result
// words and the sequencer state encoding.
package fpu_pkg;

    localparam logic [2:0]  OP_ADD      = 3'd0;
    localparam logic [2:0]  OP_SUB      = 3'd1;
    localparam logic [2:0]  OP_MUL      = 3'd3;
    localparam logic [2:0]  OP_DIV      = 3'd4;

    localparam logic [31:0] QNAN        = 32'h7FC0_0000;
    localparam logic [31:0] ILLEGAL_RES = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin select: first active request at or after ptr_i,
// ascending with wrap. Returns a one-hot grant and its index.
module rr_picker #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [IW-1:0]   ptr_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW:0] cand;

    // Scan from the farthest offset down so the nearest active request is
    // the last one written and therefore wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_i} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (req_i[cand[IW-1:0]]) begin
                idx_o = cand[IW-1:0];
                any_o = 1'b1;
            end
        end
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/fpu_arbiter.sv
// Round-robin arbiter/sequencer sharing one FPU among NREQ requesters:
// accept one op, pulse fpu_valid once, wait (with timeout), return result.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0][31:0] req_a,
    input  logic [NREQ-1:0][31:0] req_b,
    input  logic [NREQ-1:0][2:0]  req_op,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [31:0]           resp_data,
    output logic                  resp_err,
    output logic [31:0]           fpu_a,
    output logic [31:0]           fpu_b,
    output logic [2:0]            fpu_op,
    output logic                  fpu_valid,
    input  logic                  fpu_ready,
    input  logic [31:0]           fpu_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state_q, state_d;
    logic [IW-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [31:0]     a_q, a_d, b_q, b_d;
    logic [2:0]      op_q, op_d;
    logic [31:0]     data_q, data_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;

    rr_picker #(.NREQ(NREQ)) u_pick (
        .ptr_i (rr_q),
        .req_i (req_valid),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // req_ready is combinational off req_valid, so gate it with rst_n to keep
    // it low while reset is held.
    assign req_ready  = (state_q == ST_IDLE && rst_n) ? pick_gnt : '0;
    assign resp_valid = (state_q == ST_RESP) ? ({{(NREQ-1){1'b0}}, 1'b1} << gnt_q) : '0;
    assign fpu_valid  = (state_q == ST_ISSUE);
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign fpu_op     = op_q;
    assign resp_data  = data_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d = pick_idx;
                    a_d   = req_a[pick_idx];
                    b_d   = req_b[pick_idx];
                    op_d  = req_op[pick_idx];
                    if (op_legal(req_op[pick_idx])) begin
                        state_d = ST_ISSUE;
                    end else begin
                        data_d  = ILLEGAL_RES;
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (fpu_ready) begin
                    data_d  = fpu_result;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    data_d  = QNAN;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready[gnt_q]) begin
                    rr_d    = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Randomized bench for fpu_arbiter with a behavioural FPU stand-in and a
// round-robin/latency reference model.
module tb_fpu_arbiter;

    localparam int NREQ = 2;
    localparam int TMO  = 15;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid, req_ready, resp_valid, resp_ready;
    logic [NREQ-1:0][31:0] req_a, req_b;
    logic [NREQ-1:0][2:0]  req_op;
    logic [31:0]           resp_data, fpu_a, fpu_b, fpu_result;
    logic                  resp_err, fpu_valid, fpu_ready;
    logic [2:0]            fpu_op;

    int errors = 0;
    int checks = 0;

    bit hang = 0;
    int stray_req = 0;
    int stray_done = 0;
    logic [2:0] legal_ops [4] = '{3'd0, 3'd1, 3'd3, 3'd4};

    fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .fpu_a      (fpu_a),
        .fpu_b      (fpu_b),
        .fpu_op     (fpu_op),
        .fpu_valid  (fpu_valid),
        .fpu_ready  (fpu_ready),
        .fpu_result (fpu_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU result: the one directed case uses the true IEEE sum,
    // everything else a scrambling function so data paths are distinguishable.
    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000 && op == 3'd0) return 32'h4040_0000;
        return (a ^ {b[15:0], b[31:16]}) + {29'd0, op};
    endfunction

    // Cycles from fpu_valid to ready pulse, chosen so responses land at the
    // nominal latencies (ADD/SUB 4, MUL 5, DIV 7).
    function automatic int fpu_lat(input logic [2:0] op);
        case (op)
            3'd3:    return 3;
            3'd4:    return 5;
            default: return 2;
        endcase
    endfunction

    function automatic bit ref_legal(input logic [2:0] op);
        return op == 3'd0 || op == 3'd1 || op == 3'd3 || op == 3'd4;
    endfunction

    function automatic int ref_resp_cycle(input logic [2:0] op, input bit hung);
        if (!ref_legal(op)) return 1;
        if (hung) return 2 + TMO;
        case (op)
            3'd3:    return 5;
            3'd4:    return 7;
            default: return 4;
        endcase
    endfunction

    // Behavioural FPU: drives ready/result at negedges only.
    always @(negedge clk or negedge rst_n) begin
        static int cd = 0;
        static logic [31:0] pend = '0;
        if (!rst_n) begin
            cd = 0;
            fpu_ready = 1'b0;
            fpu_result = '0;
        end else begin
            fpu_result = $urandom();
            fpu_ready = 1'b0;
            if (stray_req != stray_done) begin
                fpu_ready = 1'b1;
                stray_done = stray_req;
            end
            if (fpu_valid && !hang) begin
                cd = fpu_lat(fpu_op);
                pend = fpu_fn(fpu_a, fpu_b, fpu_op);
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fpu_ready = 1'b1;
                    fpu_result = pend;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        resp_ready = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One isolated transaction from requester r; reports what it observed.
    task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, output int lat, output int fv_cyc,
                          output logic [31:0] data, output logic err,
                          output logic [NREQ-1:0] rv, output int np, output bit rdy_ok);
        @(negedge clk);
        req_a[r] = a;
        req_b[r] = b;
        req_op[r] = op;
        req_valid[r] = 1'b1;
        #1 rdy_ok = (req_ready === NREQ'(1 << r));
        @(posedge clk);
        #1 req_valid[r] = 1'b0;
        lat = -1; fv_cyc = -1; np = 0; data = '0; err = 1'b0; rv = '0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (fpu_valid === 1'b1) begin
                np++;
                if (fv_cyc < 0) fv_cyc = c;
            end
            if (resp_valid !== '0) begin
                lat = c; data = resp_data; err = resp_err; rv = resp_valid;
            end
        end
        resp_ready[r] = 1'b1;
        @(posedge clk);
        #1 resp_ready[r] = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 2'b11;
        resp_ready = '0;
        req_a = {$urandom(), $urandom()};
        req_b = {$urandom(), $urandom()};
        req_op = '0;
        #12;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid got %b want 00", resp_valid); end
        checks++; if (fpu_valid !== 1'b0) begin errors++; $display("FAIL reset_fpu_valid got %b want 0", fpu_valid); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err got %b want 0", resp_err); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data got %h want 0", resp_data); end
        checks++; if (fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_op !== 3'h0) begin
            errors++; $display("FAIL reset_fpu_operands got %h/%h/%h want 0/0/0", fpu_a, fpu_b, fpu_op);
        end
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_single_add();
        int lat, fv, np; logic [31:0] d; logic e; logic [NREQ-1:0] rv; bit ok;
        do_txn(0, 32'h3F80_0000, 32'h4000_0000, 3'd0, lat, fv, d, e, rv, np, ok);
        checks++; if (!ok) begin errors++; $display("FAIL add_req_ready not granted to req0"); end
        checks++; if (fv !== 1 || np !== 1) begin errors++; $display("FAIL add_fpu_valid cycle %0d count %0d want 1/1", fv, np); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (rv !== 2'b01 || d !== 32'h4040_0000 || e !== 1'b0) begin
            errors++; $display("FAIL add_resp got rv=%b data=%h err=%b want 01/40400000/0", rv, d, e);
        end
    endtask

    task automatic test_illegal();
        int lat, fv, np; logic [31:0] d; logic e; logic [NREQ-1:0] rv; bit ok;
        do_txn(1, $urandom(), $urandom(), 3'b111, lat, fv, d, e, rv, np, ok);
        checks++; if (np !== 0) begin errors++; $display("FAIL illegal_fpu_valid got %0d pulses want 0", np); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency got %0d want 1", lat); end
        checks++; if (rv !== 2'b10 || d !== 32'hFFFF_FFFF || e !== 1'b1) begin
            errors++; $display("FAIL illegal_resp got rv=%b data=%h err=%b want 10/ffffffff/1", rv, d, e);
        end
    endtask

    task automatic test_contention();
        int ptr, win, c; logic [31:0] expd;
        do_reset();
        ptr = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                req_a[i] = $urandom(); req_b[i] = $urandom();
                req_op[i] = legal_ops[$urandom_range(0, 3)];
            end
            req_valid = 2'b11;
            win = -1;
            for (int j = 0; j < NREQ; j++)
                if (win < 0 && req_valid[(ptr + j) % NREQ]) win = (ptr + j) % NREQ;
            expd = fpu_fn(req_a[win], req_b[win], req_op[win]);
            #1;
            checks++; if (req_ready !== NREQ'(1 << win)) begin
                errors++; $display("FAIL contention_grant[%0d] got %b want %b", k, req_ready, NREQ'(1 << win));
            end
            @(posedge clk);
            c = 0;
            do begin @(negedge clk); c++; end while (resp_valid === '0 && c < 30);
            checks++; if (resp_valid !== NREQ'(1 << win) || resp_data !== expd || resp_err !== 1'b0) begin
                errors++; $display("FAIL contention_resp[%0d] got rv=%b data=%h err=%b want %b/%h/0",
                                   k, resp_valid, resp_data, resp_err, NREQ'(1 << win), expd);
            end
            resp_ready = 2'b11;
            @(posedge clk);
            #1 resp_ready = 2'b00;
            ptr = (win + 1) % NREQ;
        end
        @(negedge clk);
        req_valid = '0;
    endtask

    task automatic test_random_ops();
        int lat, fv, np, r; logic [31:0] a, b, d; logic [2:0] op; logic e; logic [NREQ-1:0] rv; bit ok, lg;
        for (int k = 0; k < 10; k++) begin
            r = $urandom_range(0, NREQ - 1);
            op = 3'($urandom_range(0, 7));
            a = $urandom(); b = $urandom();
            lg = ref_legal(op);
            do_txn(r, a, b, op, lat, fv, d, e, rv, np, ok);
            checks++; if (lat !== ref_resp_cycle(op, 1'b0) || np !== (lg ? 1 : 0)) begin
                errors++; $display("FAIL rand_timing[%0d] op=%0d lat=%0d pulses=%0d want %0d/%0d",
                                   k, op, lat, np, ref_resp_cycle(op, 1'b0), lg ? 1 : 0);
            end
            checks++; if (rv !== NREQ'(1 << r) || d !== (lg ? fpu_fn(a, b, op) : 32'hFFFF_FFFF) || e !== !lg) begin
                errors++; $display("FAIL rand_resp[%0d] op=%0d got rv=%b data=%h err=%b want %b/%h/%b", k, op,
                                   rv, d, e, NREQ'(1 << r), lg ? fpu_fn(a, b, op) : 32'hFFFF_FFFF, !lg);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, fv, np, bad; logic [31:0] d, a, b; logic e; logic [NREQ-1:0] rv; bit ok;
        hang = 1;
        do_txn(0, $urandom(), $urandom(), 3'd0, lat, fv, d, e, rv, np, ok);
        checks++; if (lat !== ref_resp_cycle(3'd0, 1'b1)) begin
            errors++; $display("FAIL timeout_latency got %0d want %0d", lat, ref_resp_cycle(3'd0, 1'b1));
        end
        checks++; if (rv !== 2'b01 || d !== 32'h7FC0_0000 || e !== 1'b1) begin
            errors++; $display("FAIL timeout_resp got rv=%b data=%h err=%b want 01/7fc00000/1", rv, d, e);
        end
        hang = 0;
        @(negedge clk);
        #1 stray_req++;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid !== '0 || fpu_valid !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL stray_ready reacted in %0d cycles want 0", bad); end
        a = $urandom(); b = $urandom();
        do_txn(1, a, b, 3'd1, lat, fv, d, e, rv, np, ok);
        checks++; if (lat !== 4 || d !== fpu_fn(a, b, 3'd1) || e !== 1'b0) begin
            errors++; $display("FAIL post_stray got lat=%0d data=%h err=%b want 4/%h/0", lat, d, e, fpu_fn(a, b, 3'd1));
        end
    endtask

    task automatic test_backpressure();
        int c, bad; logic [31:0] a, b, held;
        a = $urandom() | 32'h1; b = $urandom();
        @(negedge clk);
        req_a[0] = a; req_b[0] = b; req_op[0] = 3'd4; req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        c = 0;
        do begin @(negedge clk); c++; end while (resp_valid === '0 && c < 30);
        checks++; if (c !== 7) begin errors++; $display("FAIL bp_div_latency got %0d want 7", c); end
        held = resp_data;
        checks++; if (held !== fpu_fn(a, b, 3'd4)) begin
            errors++; $display("FAIL bp_div_data got %h want %h", held, fpu_fn(a, b, 3'd4));
        end
        req_a[1] = $urandom(); req_op[1] = 3'd0; req_valid = 2'b10;
        resp_ready = 2'b10;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid !== 2'b01 || resp_data !== held || req_ready !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL bp_hold unstable in %0d of 10 cycles want 0", bad); end
        resp_ready = 2'b01;
        @(posedge clk);
        #1 resp_ready = 2'b00;
        @(negedge clk);
        checks++; if (req_ready !== 2'b10 || resp_valid !== 2'b00) begin
            errors++; $display("FAIL bp_release got req_ready=%b resp_valid=%b want 10/00", req_ready, resp_valid);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid_wait();
        int lat, fv, np; logic [31:0] d, a, b; logic e; logic [NREQ-1:0] rv; bit ok;
        @(negedge clk);
        req_a[0] = $urandom() | 32'h1; req_b[0] = $urandom() | 32'h1; req_op[0] = 3'd3; req_valid = 2'b01;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (2) @(negedge clk);
        req_valid = 2'b11;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 2'b00 || fpu_valid !== 1'b0 || req_ready !== 2'b00 || resp_err !== 1'b0) begin
            errors++; $display("FAIL midrst_ctrl got rv=%b fv=%b rr=%b err=%b want 00/0/00/0",
                               resp_valid, fpu_valid, req_ready, resp_err);
        end
        checks++; if (resp_data !== 32'h0 || fpu_a !== 32'h0 || fpu_b !== 32'h0 || fpu_op !== 3'h0) begin
            errors++; $display("FAIL midrst_data got %h %h %h %h want all 0", resp_data, fpu_a, fpu_b, fpu_op);
        end
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        a = $urandom(); b = $urandom();
        do_txn(1, a, b, 3'd3, lat, fv, d, e, rv, np, ok);
        checks++; if (!ok || lat !== 5 || rv !== 2'b10 || d !== fpu_fn(a, b, 3'd3) || e !== 1'b0) begin
            errors++; $display("FAIL midrst_after got ok=%0d lat=%0d rv=%b data=%h err=%b want 1/5/10/%h/0",
                               ok, lat, rv, d, e, fpu_fn(a, b, 3'd3));
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_illegal();
        test_contention();
        test_random_ops();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
